// File: rtl/pc_irq_sequencer_pkg.sv
// Shared control-signal encodings for the PC / IRQ-entry path, plus the sequencer
// defaults and its state encoding.
package pc_irq_sequencer_pkg;
  localparam int unsigned DEF_ADDR_W     = 16;
  localparam logic [15:0] DEF_RESET_PC   = 16'h0000;
  localparam logic [15:0] DEF_IRQ_VECTOR = 16'h0010;
endpackage

package pc_data_source_t;
  typedef enum logic [1:0] {next_pc, register, irq, mem} t;
endpackage

package mem_write_addr_source_t;
  typedef enum logic {sp, alu} t;
endpackage

package mem_write_data_source_t;
  typedef enum logic {next_pc, sr} t;
endpackage

package irq_seq_state_t;
  typedef enum logic [1:0] {idle, push_pc, push_sr, vector} t;
endpackage

// File: rtl/pc_irq_sequencer_pc_next_mux.sv
// Next-instruction target select and PC incrementer; purely combinational.
module pc_irq_sequencer_pc_next_mux
  import pc_irq_sequencer_pkg::*;
#(
  parameter int unsigned        ADDR_W     = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0]  IRQ_VECTOR = DEF_IRQ_VECTOR
) (
  input  logic [ADDR_W-1:0] this_pc_i,
  input  pc_data_source_t::t pc_src_i,
  input  logic [ADDR_W-1:0] reg_data_i,
  input  logic [ADDR_W-1:0] mem_data_i,
  output logic [ADDR_W-1:0] next_pc_o,
  output logic [ADDR_W-1:0] target_o
);

  // Truncating add gives the required wrap from all-ones back to zero.
  assign next_pc_o = this_pc_i + ADDR_W'(1);

  always_comb begin
    target_o = next_pc_o;
    case (pc_src_i)
      pc_data_source_t::next_pc:  target_o = next_pc_o;
      pc_data_source_t::register: target_o = reg_data_i;
      pc_data_source_t::irq:      target_o = IRQ_VECTOR;
      pc_data_source_t::mem:      target_o = mem_data_i;
      default:                    target_o = next_pc_o;
    endcase
  end

endmodule

// File: rtl/pc_irq_sequencer.sv
// Program counter owner: advances the PC on instruction boundaries and, on an
// accepted interrupt, pushes return PC and SR onto the stack before vectoring.
module pc_irq_sequencer
  import pc_irq_sequencer_pkg::*;
#(
  parameter int unsigned        ADDR_W     = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0]  RESET_PC   = DEF_RESET_PC,
  parameter logic [ADDR_W-1:0]  IRQ_VECTOR = DEF_IRQ_VECTOR
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      step_i,
  input  pc_data_source_t::t        pc_src_i,
  input  logic [ADDR_W-1:0]         reg_data_i,
  input  logic [ADDR_W-1:0]         mem_data_i,
  input  logic [ADDR_W-1:0]         sr_in_i,
  input  logic                      irq_req_i,
  input  logic                      irq_en_i,
  input  logic                      push_ready_i,
  output logic [ADDR_W-1:0]         this_pc_o,
  output logic [ADDR_W-1:0]         next_pc_o,
  output logic                      push_valid_o,
  output mem_write_addr_source_t::t push_addr_sel_o,
  output mem_write_data_source_t::t push_data_sel_o,
  output logic [ADDR_W-1:0]         push_data_o,
  output logic                      sp_dec_o,
  output logic                      irq_busy_o,
  output logic                      irq_ack_o
);

  irq_seq_state_t::t  state_q, state_d;
  logic [ADDR_W-1:0]  this_pc_q, this_pc_d;
  logic [ADDR_W-1:0]  ret_pc_q, ret_pc_d;
  logic [ADDR_W-1:0]  sr_lat_q, sr_lat_d;
  logic [ADDR_W-1:0]  target;

  pc_irq_sequencer_pc_next_mux #(
    .ADDR_W     (ADDR_W),
    .IRQ_VECTOR (IRQ_VECTOR)
  ) u_pc_next_mux (
    .this_pc_i  (this_pc_q),
    .pc_src_i   (pc_src_i),
    .reg_data_i (reg_data_i),
    .mem_data_i (mem_data_i),
    .next_pc_o  (next_pc_o),
    .target_o   (target)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= irq_seq_state_t::idle;
      this_pc_q <= RESET_PC;
      ret_pc_q  <= '0;
      sr_lat_q  <= '0;
    end else begin
      state_q   <= state_d;
      this_pc_q <= this_pc_d;
      ret_pc_q  <= ret_pc_d;
      sr_lat_q  <= sr_lat_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    this_pc_d       = this_pc_q;
    ret_pc_d        = ret_pc_q;
    sr_lat_d        = sr_lat_q;
    push_valid_o    = 1'b0;
    push_addr_sel_o = mem_write_addr_source_t::sp;
    push_data_sel_o = mem_write_data_source_t::next_pc;
    push_data_o     = '0;
    irq_ack_o       = 1'b0;

    case (state_q)
      irq_seq_state_t::idle: begin
        if (step_i) begin
          // The return address is whatever this boundary would otherwise have jumped to.
          if (irq_req_i && irq_en_i) begin
            ret_pc_d = target;
            sr_lat_d = sr_in_i;
            state_d  = irq_seq_state_t::push_pc;
          end else begin
            this_pc_d = target;
          end
        end
      end
      irq_seq_state_t::push_pc: begin
        push_valid_o = 1'b1;
        push_data_o  = ret_pc_q;
        if (push_ready_i) state_d = irq_seq_state_t::push_sr;
      end
      irq_seq_state_t::push_sr: begin
        push_valid_o    = 1'b1;
        push_data_sel_o = mem_write_data_source_t::sr;
        push_data_o     = sr_lat_q;
        if (push_ready_i) state_d = irq_seq_state_t::vector;
      end
      irq_seq_state_t::vector: begin
        this_pc_d = IRQ_VECTOR;
        irq_ack_o = 1'b1;
        state_d   = irq_seq_state_t::idle;
      end
      default: state_d = irq_seq_state_t::idle;
    endcase

    // Reset aborts the sequence in the same cycle so no push is accepted under it.
    if (reset_i) begin
      push_valid_o    = 1'b0;
      push_data_sel_o = mem_write_data_source_t::next_pc;
      push_data_o     = '0;
      irq_ack_o       = 1'b0;
    end
  end

  assign sp_dec_o   = push_valid_o & push_ready_i;
  assign irq_busy_o = (state_q != irq_seq_state_t::idle);
  assign this_pc_o  = this_pc_q;

endmodule

// File: tb/tb_pc_irq_sequencer.sv
// Directed bench for pc_irq_sequencer: PC stepping, wrap, IRQ entry, backpressure and reset abort.
module tb_pc_irq_sequencer;

  logic                      clk;
  logic                      reset;
  logic                      step;
  pc_data_source_t::t        pc_src;
  logic [15:0]               reg_data;
  logic [15:0]               mem_data;
  logic [15:0]               sr_in;
  logic                      irq_req;
  logic                      irq_en;
  logic                      push_ready;
  logic [15:0]               this_pc;
  logic [15:0]               next_pc;
  logic                      push_valid;
  mem_write_addr_source_t::t push_addr_sel;
  mem_write_data_source_t::t push_data_sel;
  logic [15:0]               push_data;
  logic                      sp_dec;
  logic                      irq_busy;
  logic                      irq_ack;

  int n_checks = 0;
  int n_fail   = 0;

  pc_irq_sequencer dut (
    .clk_i           (clk),
    .reset_i         (reset),
    .step_i          (step),
    .pc_src_i        (pc_src),
    .reg_data_i      (reg_data),
    .mem_data_i      (mem_data),
    .sr_in_i         (sr_in),
    .irq_req_i       (irq_req),
    .irq_en_i        (irq_en),
    .push_ready_i    (push_ready),
    .this_pc_o       (this_pc),
    .next_pc_o       (next_pc),
    .push_valid_o    (push_valid),
    .push_addr_sel_o (push_addr_sel),
    .push_data_sel_o (push_data_sel),
    .push_data_o     (push_data),
    .sp_dec_o        (sp_dec),
    .irq_busy_o      (irq_busy),
    .irq_ack_o       (irq_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  localparam logic [15:0] SEL_NEXT = 16'(mem_write_data_source_t::next_pc);
  localparam logic [15:0] SEL_SR   = 16'(mem_write_data_source_t::sr);
  localparam logic [15:0] ADDR_SP  = 16'(mem_write_addr_source_t::sp);

  initial begin
    reset      = 1'b1;
    step       = 1'b1;
    pc_src     = pc_data_source_t::register;
    reg_data   = 16'h1234;
    mem_data   = 16'h0000;
    sr_in      = 16'h0000;
    irq_req    = 1'b0;
    irq_en     = 1'b0;
    push_ready = 1'b1;
    @(negedge clk);
    tick();
    check("reset_pc",     this_pc,           16'h0000);
    check("reset_valid",  16'(push_valid),   16'h0000);
    check("reset_busy",   16'(irq_busy),     16'h0000);
    check("reset_ack",    16'(irq_ack),      16'h0000);
    check("reset_data",   push_data,         16'h0000);
    check("reset_nextpc", next_pc,           16'h0001);

    reset    = 1'b0;
    reg_data = 16'hFFFF;
    tick();
    check("load_ffff",   this_pc, 16'hFFFF);
    check("nextpc_wrap", next_pc, 16'h0000);
    pc_src = pc_data_source_t::next_pc;
    tick();
    check("step_wrap", this_pc, 16'h0000);

    step = 1'b0;
    tick();
    check("no_step_hold", this_pc, 16'h0000);

    step     = 1'b1;
    pc_src   = pc_data_source_t::register;
    reg_data = 16'h0040;
    tick();
    check("load_0040", this_pc, 16'h0040);

    // IRQ entry with push_ready held high
    pc_src     = pc_data_source_t::next_pc;
    sr_in      = 16'h8001;
    irq_req    = 1'b1;
    irq_en     = 1'b1;
    push_ready = 1'b1;
    tick();
    step = 1'b0;
    check("pc_push_valid", 16'(push_valid),    16'h0001);
    check("pc_push_data",  push_data,          16'h0041);
    check("pc_push_sel",   16'(push_data_sel), SEL_NEXT);
    check("pc_push_addr",  16'(push_addr_sel), ADDR_SP);
    check("pc_push_spdec", 16'(sp_dec),        16'h0001);
    check("pc_push_busy",  16'(irq_busy),      16'h0001);
    check("pc_push_thispc", this_pc,           16'h0040);
    check("pc_push_ack",   16'(irq_ack),       16'h0000);
    tick();
    check("sr_push_valid", 16'(push_valid),    16'h0001);
    check("sr_push_data",  push_data,          16'h8001);
    check("sr_push_sel",   16'(push_data_sel), SEL_SR);
    check("sr_push_spdec", 16'(sp_dec),        16'h0001);
    tick();
    check("vec_ack",    16'(irq_ack),       16'h0001);
    check("vec_valid",  16'(push_valid),    16'h0000);
    check("vec_spdec",  16'(sp_dec),        16'h0000);
    check("vec_sel",    16'(push_data_sel), SEL_NEXT);
    check("vec_thispc", this_pc,            16'h0040);
    check("vec_busy",   16'(irq_busy),      16'h0001);
    tick();
    check("post_vec_pc",   this_pc,        16'h0010);
    check("post_vec_busy", 16'(irq_busy),  16'h0000);
    check("post_vec_ack",  16'(irq_ack),   16'h0000);
    check("post_vec_next", next_pc,        16'h0011);

    // Backpressure in PUSH_PC, then reset while in PUSH_SR
    step       = 1'b1;
    pc_src     = pc_data_source_t::register;
    reg_data   = 16'h0300;
    sr_in      = 16'h0005;
    push_ready = 1'b0;
    tick();
    reg_data = 16'hBEEF;
    sr_in    = 16'hAAAA;
    for (int i = 0; i < 3; i++) begin
      check("bp_valid",  16'(push_valid), 16'h0001);
      check("bp_data",   push_data,       16'h0300);
      check("bp_spdec",  16'(sp_dec),     16'h0000);
      check("bp_thispc", this_pc,         16'h0010);
      check("bp_busy",   16'(irq_busy),   16'h0001);
      tick();
    end
    push_ready = 1'b1;
    #1;
    check("bp_accept_spdec", 16'(sp_dec), 16'h0001);
    check("bp_accept_data",  push_data,   16'h0300);
    tick();
    push_ready = 1'b0;
    step       = 1'b0;
    #1;
    check("bp_sr_data",  push_data,          16'h0005);
    check("bp_sr_sel",   16'(push_data_sel), SEL_SR);
    check("bp_sr_spdec", 16'(sp_dec),        16'h0000);
    reset = 1'b1;
    #1;
    check("rst_abort_valid", 16'(push_valid), 16'h0000);
    tick();
    reset = 1'b0;
    check("rst_sr_busy",  16'(irq_busy),   16'h0000);
    check("rst_sr_valid", 16'(push_valid), 16'h0000);
    check("rst_sr_pc",    this_pc,         16'h0000);
    check("rst_sr_ack",   16'(irq_ack),    16'h0000);
    tick();
    check("rst_sr_ack2", 16'(irq_ack), 16'h0000);
    check("rst_sr_pc2",  this_pc,      16'h0000);

    // Masked IRQ: normal mem-sourced step, no push
    irq_req  = 1'b1;
    irq_en   = 1'b0;
    step     = 1'b1;
    pc_src   = pc_data_source_t::mem;
    mem_data = 16'h0200;
    tick();
    check("masked_pc",    this_pc,         16'h0200);
    check("masked_valid", 16'(push_valid), 16'h0000);
    check("masked_busy",  16'(irq_busy),   16'h0000);

    // Software trap: pc_src==irq without a pending IRQ vectors directly
    irq_req = 1'b0;
    pc_src  = pc_data_source_t::irq;
    tick();
    step = 1'b0;
    check("trap_pc",    this_pc,         16'h0010);
    check("trap_valid", 16'(push_valid), 16'h0000);
    check("trap_busy",  16'(irq_busy),   16'h0000);
    check("trap_ack",   16'(irq_ack),    16'h0000);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
